// File: rtl/sys_block_meas.sv
// Board system block: ID/revision constants, scratch registers, uptime counter
// and gated edge-count frequency measurement of asynchronous aux clocks.
module sys_block_meas #(
  parameter logic [15:0] BOARD_ID    = 16'hdead,
  parameter logic [15:0] REV_MAJOR   = 16'haaaa,
  parameter logic [15:0] REV_MINOR   = 16'hbbbb,
  parameter logic [15:0] REV_RCS     = 16'hcccc,
  parameter int          NUM_SCRATCH = 2,
  parameter int          NUM_AUX     = 2,
  parameter logic [23:0] GATE_CYCLES = 24'd10000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [1:0]         wb_sel_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [15:0]        wb_dat_i,
  output logic [15:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic [NUM_AUX-1:0] aux_clk
);

  // state   | meaning
  // S_IDLE  | no window; counters held clear
  // S_RUN   | gate window open, edges counted
  // S_LATCH | one cycle: publish counts to FREQ, set done, bump gen
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LATCH} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ack;
  logic [15:0]         r_dat;
  logic                r_meas_en, r_done;
  logic [7:0]          r_gen;
  logic [31:0]         r_uptime;
  logic [15:0]         r_shadow;
  logic [23:0]         r_gate;
  logic [NUM_AUX-1:0]  r_sync1, r_sync2, r_hist;
  logic [15:0]         r_scratch  [NUM_SCRATCH];
  logic [15:0]         r_freq     [NUM_AUX];
  logic [15:0]         r_edge_cnt [NUM_AUX];
  logic [15:0]         w_cnt_nxt  [NUM_AUX];
  logic [NUM_AUX-1:0]  w_rise;
  logic                w_accept, w_wr, w_start, w_done_clr, w_gate_end;
  logic [4:0]          w_idx;
  logic [15:0]         w_rdata;
  logic                w_unused_adr;

  assign w_accept     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr         = w_accept & wb_we_i;
  assign w_idx        = wb_adr_i[5:1];
  assign w_start      = w_wr & (w_idx == 5'd4) & wb_sel_i[0] & wb_dat_i[1];
  assign w_done_clr   = w_wr & (w_idx == 5'd5) & wb_sel_i[0] & wb_dat_i[1];
  assign w_gate_end   = (r_gate == GATE_CYCLES - 24'd1);
  assign w_rise       = r_sync2 & ~r_hist;
  assign w_unused_adr = ^{wb_adr_i[31:6], wb_adr_i[0]};
  assign wb_ack_o     = r_ack;
  assign wb_dat_o     = r_dat;

  // Includes the edge seen this cycle, so LATCH can publish it directly.
  always_comb begin
    for (int n = 0; n < NUM_AUX; n++)
      w_cnt_nxt[n] = (r_edge_cnt[n] == 16'hFFFF) ? r_edge_cnt[n]
                                                 : r_edge_cnt[n] + 16'(w_rise[n]);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_meas_en || w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_gate_end) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = r_meas_en ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_gate  <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
      r_done  <= 1'b0;
      r_gen   <= '0;
      for (int n = 0; n < NUM_AUX; n++) begin
        r_edge_cnt[n] <= '0;
        r_freq[n]     <= '0;
      end
    end else begin
      r_sync1 <= aux_clk;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      case (r_state)
        S_RUN: begin
          r_gate <= r_gate + 24'd1;
          for (int n = 0; n < NUM_AUX; n++) r_edge_cnt[n] <= w_cnt_nxt[n];
        end
        S_LATCH: begin
          r_gate <= '0;
          for (int n = 0; n < NUM_AUX; n++) begin
            r_freq[n]     <= w_cnt_nxt[n];
            r_edge_cnt[n] <= '0;
          end
        end
        default: begin
          r_gate <= '0;
          for (int n = 0; n < NUM_AUX; n++) r_edge_cnt[n] <= '0;
        end
      endcase
      // A LATCH wins over a simultaneous done clear.
      if (r_state == S_LATCH) begin
        r_done <= 1'b1;
        r_gen  <= r_gen + 8'd1;
      end else if (w_done_clr) begin
        r_done <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      5'd0:    w_rdata = BOARD_ID;
      5'd1:    w_rdata = REV_MAJOR;
      5'd2:    w_rdata = REV_MINOR;
      5'd3:    w_rdata = REV_RCS;
      5'd4:    w_rdata = {15'd0, r_meas_en};
      5'd5:    w_rdata = {r_gen, 6'd0, r_done, (r_state == S_RUN)};
      5'd6:    w_rdata = r_uptime[15:0];
      5'd7:    w_rdata = r_shadow;
      default: w_rdata = '0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (w_idx == 5'(8 + i)) w_rdata = r_scratch[i];
    for (int n = 0; n < NUM_AUX; n++)
      if (w_idx == 5'(16 + n)) w_rdata = r_freq[n];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_meas_en <= 1'b0;
      r_uptime  <= '0;
      r_shadow  <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
    end else begin
      r_ack    <= w_accept;
      r_uptime <= r_uptime + 32'd1;
      if (w_accept) r_dat <= w_rdata;
      // Snapshot the high half when the low half is read so LO/HI pairs agree.
      if (w_accept && !wb_we_i && w_idx == 5'd6) r_shadow <= r_uptime[31:16];
      if (w_wr && w_idx == 5'd4 && wb_sel_i[0]) r_meas_en <= wb_dat_i[0];
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_wr && w_idx == 5'(8 + i)) begin
          if (wb_sel_i[0]) r_scratch[i][7:0]  <= wb_dat_i[7:0];
          if (wb_sel_i[1]) r_scratch[i][15:8] <= wb_dat_i[15:8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sys_block_meas.sv
// Directed bench for sys_block_meas with a 100-cycle gate window.
module tb_sys_block_meas;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] adr = '0;
  logic [15:0] wdat = '0;
  logic [15:0] dat_o;
  logic        ack;
  logic        aux0 = 1'b0, aux_run = 1'b0, aux_div = 1'b0;
  int          n_cmp = 0, n_fail = 0;
  int          cyc_cnt = 0, acc_cyc = 0, rel_cnt = 0;

  sys_block_meas #(.GATE_CYCLES(24'd100)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .aux_clk({1'b0, aux0}));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // aux_clk[0] = clk/4, toggled on falling edges.
  always begin
    @(negedge clk);
    if (aux_run) begin
      aux_div = ~aux_div;
      if (!aux_div) aux0 = ~aux0;
    end else begin
      aux_div = 1'b0;
      aux0    = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus(input logic w, input logic [4:0] idx, input logic [15:0] d,
                     input logic [1:0] s, output logic [15:0] q,
                     output logic a1, output logic a2);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {26'd0, idx, 1'b0}; wdat = d; sel = s;
    @(posedge clk); #1;
    a1 = ack; q = dat_o; acc_cyc = cyc_cnt;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    a2 = ack;
  endtask

  // Returns just after the edge preceding cycle t, so a following bus call accepts at t.
  task automatic wait_to(input int t);
    int guard = 0;
    while (cyc_cnt < t - 1 && guard < 100000) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] q;
    logic a1, a2;
    int          ids [6]   = '{0, 1, 2, 3, 31, 8};
    logic [15:0] exp_v [6] = '{16'hdead, 16'haaaa, 16'hbbbb, 16'hcccc, 16'h0000, 16'h0000};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ack !== 1'b0 || dat_o !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outputs: ack=%b dat=%h want 0/0000", ack, dat_o);
    end
    @(negedge clk);
    rst = 1'b0; rel_cnt = cyc_cnt;
    for (int i = 0; i < 6; i++) begin
      bus(1'b0, 5'(ids[i]), 16'h0, 2'b11, q, a1, a2);
      n_cmp++;
      if (q !== exp_v[i]) begin
        n_fail++; $display("FAIL reset_read idx%0d: got %h want %h", ids[i], q, exp_v[i]);
      end
      n_cmp++;
      if (a1 !== 1'b1 || a2 !== 1'b0) begin
        n_fail++; $display("FAIL ack_width idx%0d: ack=%b,%b want 1,0", ids[i], a1, a2);
      end
    end
  endtask

  task automatic test_scratch();
    logic [15:0] q;
    logic a1, a2;
    bus(1'b1, 5'd8, 16'h1234, 2'b01, q, a1, a2);
    bus(1'b1, 5'd8, 16'hABCD, 2'b10, q, a1, a2);
    bus(1'b0, 5'd8, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'hAB34) begin n_fail++; $display("FAIL scratch0_lanes: got %h want ab34", q); end
    bus(1'b0, 5'd9, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0000) begin n_fail++; $display("FAIL scratch1_untouched: got %h want 0000", q); end
    bus(1'b1, 5'd9, 16'h5A5A, 2'b11, q, a1, a2);
    bus(1'b0, 5'd9, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h5A5A) begin n_fail++; $display("FAIL scratch1_full: got %h want 5a5a", q); end
    bus(1'b1, 5'd0, 16'h1111, 2'b11, q, a1, a2);
    n_cmp++;
    if (a1 !== 1'b1) begin n_fail++; $display("FAIL ro_write_ack: ack=%b want 1", a1); end
    bus(1'b0, 5'd0, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'hdead) begin n_fail++; $display("FAIL ro_write_ignored: got %h want dead", q); end
    bus(1'b0, 5'd8, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'hAB34) begin n_fail++; $display("FAIL scratch0_kept: got %h want ab34", q); end
  endtask

  task automatic test_single_meas();
    logic [15:0] q;
    logic a1, a2, found;
    int busy_n;
    busy_n = 0; found = 1'b0;
    bus(1'b1, 5'd4, 16'h0002, 2'b01, q, a1, a2);
    aux_run = 1'b1;
    bus(1'b1, 5'd4, 16'h0002, 2'b01, q, a1, a2);
    for (int k = 0; k < 80 && !found; k++) begin
      bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
      if (q[0]) busy_n++;
      else found = 1'b1;
    end
    n_cmp++;
    if (!found || q !== 16'h0102) begin
      n_fail++; $display("FAIL single_status: got %h found=%b want 0102", q, found);
    end
    n_cmp++;
    if (busy_n != 49) begin n_fail++; $display("FAIL busy_length: busy polls %0d want 49", busy_n); end
    bus(1'b0, 5'd16, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'd24 && q !== 16'd25) begin
      n_fail++; $display("FAIL freq0: got %0d want 24 or 25", q);
    end
    aux_run = 1'b0;
    bus(1'b0, 5'd17, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0000) begin n_fail++; $display("FAIL freq1: got %h want 0000", q); end
    bus(1'b0, 5'd18, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0000) begin n_fail++; $display("FAIL freq_unmapped: got %h want 0000", q); end
    wait_to(cyc_cnt + 120);
    bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0102) begin n_fail++; $display("FAIL start_ignored_gen: got %h want 0102", q); end
  endtask

  task automatic test_continuous();
    logic [15:0] q;
    logic a1, a2;
    int e;
    bus(1'b1, 5'd5, 16'h0002, 2'b01, q, a1, a2);
    bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0100) begin n_fail++; $display("FAIL w1c_idle: got %h want 0100", q); end
    bus(1'b1, 5'd4, 16'h0001, 2'b01, q, a1, a2);
    e = acc_cyc;
    bus(1'b0, 5'd4, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0001) begin n_fail++; $display("FAIL ctrl_read: got %h want 0001", q); end
    wait_to(e + 150);
    bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0203) begin n_fail++; $display("FAIL cont_gen2: got %h want 0203", q); end
    wait_to(e + 160);
    bus(1'b1, 5'd5, 16'h0002, 2'b01, q, a1, a2);
    bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0201) begin n_fail++; $display("FAIL w1c_run: got %h want 0201", q); end
    wait_to(e + 203);
    bus(1'b1, 5'd5, 16'h0002, 2'b01, q, a1, a2);
    bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0303) begin n_fail++; $display("FAIL w1c_vs_latch: got %h want 0303", q); end
    wait_to(e + 210);
    bus(1'b1, 5'd4, 16'h0000, 2'b01, q, a1, a2);
    wait_to(e + 300);
    bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0303) begin n_fail++; $display("FAIL window_finishing: got %h want 0303", q); end
    wait_to(e + 310);
    bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0402) begin n_fail++; $display("FAIL cont_stop: got %h want 0402", q); end
  endtask

  task automatic test_uptime();
    logic [15:0] q, exp_lo;
    logic a1, a2;
    wait_to(rel_cnt + 1 + 32'h0000FFFF);
    bus(1'b0, 5'd6, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'hFFFF) begin n_fail++; $display("FAIL uptime_lo: got %h want ffff", q); end
    bus(1'b0, 5'd7, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0000) begin n_fail++; $display("FAIL uptime_hi_coherent: got %h want 0000", q); end
    bus(1'b0, 5'd6, 16'h0, 2'b11, q, a1, a2);
    exp_lo = 16'(acc_cyc - 1 - rel_cnt);
    n_cmp++;
    if (q !== exp_lo) begin n_fail++; $display("FAIL uptime_lo2: got %h want %h", q, exp_lo); end
    bus(1'b0, 5'd7, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0001) begin n_fail++; $display("FAIL uptime_hi2: got %h want 0001", q); end
  endtask

  task automatic test_async_reset();
    logic [15:0] q;
    logic a1, a2;
    aux_run = 1'b1;
    bus(1'b1, 5'd4, 16'h0002, 2'b01, q, a1, a2);
    wait_to(acc_cyc + 30);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 2'b11;
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b1 || dat_o !== 16'hdead) begin
      n_fail++; $display("FAIL pre_reset_ack: ack=%b dat=%h want 1/dead", ack, dat_o);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ack !== 1'b0 || dat_o !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset_ack: ack=%b dat=%h want 0/0000", ack, dat_o);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_to(cyc_cnt + 150);
    bus(1'b0, 5'd16, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0000) begin n_fail++; $display("FAIL freq0_after_reset: got %h want 0000", q); end
    bus(1'b0, 5'd5, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0000) begin n_fail++; $display("FAIL status_after_reset: got %h want 0000", q); end
    bus(1'b0, 5'd8, 16'h0, 2'b11, q, a1, a2);
    n_cmp++;
    if (q !== 16'h0000) begin n_fail++; $display("FAIL scratch_after_reset: got %h want 0000", q); end
    aux_run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_single_meas();
    test_continuous();
    test_uptime();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sys_block_meas.md
# sys_block_meas

Parametrised successor to the board system block: a 16-bit Wishbone slave that exposes the board ID and revision constants, a bank of byte-writable scratch registers and a 32-bit uptime counter. It also measures the frequency of up to 8 auxiliary clock inputs by counting their edges over a programmable gate window. It sits on the board-management Wishbone bus. Everything runs in the single bus clock domain; aux clocks are treated as asynchronous data inputs.

## Interface
- BOARD_ID, 16'hdead, constant returned at index 0
- REV_MAJOR / REV_MINOR / REV_RCS, 16'haaaa / 16'hbbbb / 16'hcccc, constants returned at indices 1/2/3
- NUM_SCRATCH, 2, number of scratch registers (1..8)
- NUM_AUX, 2, number of aux clock inputs measured (1..8)
- GATE_CYCLES, 24'd10000, gate window length in wb_clk_i cycles (2..2^24-1)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone strobes
- wb_sel_i  in  2  byte lane enables
- wb_adr_i  in  32  byte address; register index = wb_adr_i[5:1]
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data, registered
- wb_ack_o  out  1  transfer acknowledge, registered
- aux_clk  in  NUM_AUX  clocks to measure, asynchronous to wb_clk_i

## Operation
- Register map, by index:
  - 0–3: read-only constants.
  - 4 CTRL: bit0 meas_en (RW); bit1 start (write-1 pulse, reads 0).
  - 5 STATUS: bit0 busy (RO); bit1 done (sticky, write-1-to-clear); [15:8] gen (RO).
  - 6 UPTIME_LO; 7 UPTIME_HI.
  - 8..8+NUM_SCRATCH-1: scratch, RW.
  - 16..16+NUM_AUX-1: FREQ[n], RO edge counts.
  - All other indices read 0, ignore writes, and still ack.
- Byte lanes: wb_sel_i[0] gates bits 7:0 and wb_sel_i[1] gates bits 15:8 on every writable field. CTRL and STATUS control bits live in lane 0.
- Uptime: a 32-bit free-running counter incremented every cycle, wrapping 32'hFFFFFFFF→0.
  - Reading index 6 returns uptime[15:0] and copies uptime[31:16] into a shadow register on the same edge.
  - Index 7 returns the shadow, so a LO-then-HI read pair is coherent.
- Aux sampling: each aux_clk[n] passes through 2 synchroniser flops plus 1 history flop. A rising edge is sync2 & ~hist. Inputs must stay below wb_clk_i/2.
- Measurement FSM:
  - IDLE: busy=0. Goes to RUN on the next edge if meas_en=1 or a start write is accepted. On that transition the gate counter and all edge counters clear.
  - RUN: busy=1. The gate counter increments each cycle. Each edge counter increments on its detected rising edge and saturates at 16'hFFFF. When the gate counter reaches GATE_CYCLES-1, go to LATCH.
  - LATCH: one cycle. FREQ[n] ← edge counter n (including an edge detected in that same cycle). Set done=1 and increment gen (8-bit, wraps). Go to RUN if meas_en=1, else to IDLE.
- Start writes during RUN or LATCH are ignored. Clearing meas_en during RUN lets the current window finish, then the FSM goes to IDLE.
- If a done W1C write and LATCH land on the same edge, done ends at 1.

## Timing
- Transfer acceptance:
  - A transfer is accepted at an edge where wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o is high for exactly one cycle after that edge.
  - wb_dat_o is valid in that same cycle.
  - Register writes take effect at the accept edge.
- Throughput is one transfer per 2 cycles; there is no wait-state insertion.
- Read data is sampled at the accept edge.
- Reset (asynchronous, immediate):
  - wb_ack_o=0 and wb_dat_o=0.
  - Scratch, CTRL, STATUS, gen, uptime, shadow, FREQ, synchronisers and counters all go to 0.
  - FSM goes to IDLE.
- Reset mid-RUN aborts the window without latching.
- Window cadence: with meas_en held, successive LATCH cycles are GATE_CYCLES+1 cycles apart. FREQ ≈ f_aux·GATE_CYCLES/f_wb.
- Aux edges reach the edge counter 3 cycles after the pin transition.

## Test plan
- Reset, then read indices 0–3, 31 and 8 → 16'hdead, aaaa, bbbb, cccc, 0000, 0000. Each ack is exactly one cycle wide.
- Write 16'h1234 to scratch 0 with sel=2'b01, then sel=2'b10 with 16'hABCD → scratch 0 reads 16'hAB34. Scratch 1 is unaffected.
- GATE_CYCLES=100, aux_clk[0]=wb_clk/4, aux_clk[1] static, single start write.
  - Required: busy for 100 cycles, done=1, gen=1, FREQ0 ∈ {24,25}, FREQ1=0.
  - A start write during busy leaves gen at 1.
- Continuous mode: set meas_en, then clear it after 3 LATCH events.
  - Required: gen=3 and then 4, the window finishes, busy drops.
  - W1C of done clears it; a W1C on the same edge as a LATCH does not.
- Uptime coherence: force the uptime low half to 16'hFFFF via an elapsed-time wait, read LO then HI across the carry → the HI value matches the LO snapshot.
- Assert wb_rst_i asynchronously mid-RUN and mid-ack → ack drops at once, FREQ stays 0, FSM returns to IDLE.
